// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Shares one combinational 32-bit logical-left shifter among NREQ requesters.
// A round-robin arbiter grants at most one requester per cycle. The granted
// requester's operand is shifted by its 5-bit amount. The result is held in a
// one-deep result register, tagged with the winner's ID, until the consumer
// takes it. Requesters are held off while the register is occupied and not
// draining, so no accepted request is ever dropped or overwritten.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : [NREQ]      per-requester request valid
//   req_ready  : [NREQ]      per-requester accept (one-hot or zero)
//   req_x      : [32*NREQ]   operand of requester i at [32i+31:32i]
//   req_y      : [32*NREQ]   shift amount of requester i; only [32i+4:32i] used
//   res_valid  : result register holds an unconsumed result
//   res_ready  : consumer takes the result this cycle
//   res_z      : registered shift result
//   res_id     : index of the requester that produced res_z
// -----------------------------------------------------------------------------
module shift_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_x,
    input  logic [32*NREQ-1:0]   req_y,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_z,
    output logic [IDW-1:0]       res_id
);

    // Index of the most recently granted requester; the search starts just
    // above it so every waiting requester is reached within NREQ grants.
    logic [IDW-1:0] ptr;

    logic [IDW-1:0] cand;
    logic [IDW-1:0] win;
    logic           found;
    logic           slot_free;
    logic           grant;

    logic [31:0]    op_x   [NREQ];
    logic [4:0]     op_amt [NREQ];

    // Only the low five bits of each shift amount are meaningful; the rest
    // are deliberately ignored (an amount of 32 behaves as 0).
    logic           unused_y_hi;
    assign unused_y_hi = ^req_y;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_x[g]   = req_x[32*g +: 32];
        assign op_amt[g] = req_y[32*g +: 5];
    end

    // The slot can take a new result when it is empty or being drained in
    // this very cycle.
    assign slot_free = !res_valid || res_ready;

    // Round-robin search: ptr+1, ptr+2, ... wrapping, ending on ptr itself so
    // a lone requester is re-granted every cycle.
    // NOTE: every variable written in an always_comb gets a default on entry;
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // rst_n gates the grant so req_ready is low throughout reset.
    assign grant = found && slot_free && rst_n;

    for (genvar g = 0; g < NREQ; g++) begin : g_ready
        assign req_ready[g] = grant && (win == IDW'(g));
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_z     <= '0;
            res_id    <= '0;
            ptr       <= IDW'(NREQ - 1);
        end else if (grant) begin
            res_valid <= 1'b1;
            res_z     <= op_x[win] << op_amt[win];
            res_id    <= win;
            ptr       <= win;
        end else if (res_ready) begin
            // Drain without refill; res_z/res_id keep their last values.
            res_valid <= 1'b0;
        end
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin arbiter and one-deep result buffer that shares the combinational 32-bit logical-left shifter among up to NREQ requesters. Each requester presents an operand and a shift amount under valid/ready. The arbiter grants one requester per cycle, registers the result X << Y[4:0] with the winner's ID, and holds it until the consumer accepts it. It sits between the ALU-issue ports and the shared SLL datapath.

## Interface
- NREQ, 4, number of requesters (2..4)
- IDW, 2, width of requester ID (ceil(log2(NREQ)), min 1)
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle
- req_x  input  32*NREQ  operand for requester i at bits [32i+31:32i]
- req_y  input  32*NREQ  shift amount for requester i at bits [32i+31:32i]; only bits [32i+4:32i] used
- res_valid  output  1  result register holds an unconsumed result
- res_ready  input  1  consumer accepts result this cycle
- res_z  output  32  registered shift result
- res_id  output  IDW  index of the requester that produced res_z

## Operation
- Slot free when res_valid==0 or res_ready==1 (same-cycle drain and refill allowed).
- Arbitration (combinational): search req_valid starting at index ptr+1 mod NREQ, ascending with wrap. The first set bit wins.
- req_ready[w] = slot free & req_valid[w] & rst_n. All other req_ready bits are 0. If no request is valid, req_ready is all 0.
- Accept happens when req_valid[w] & req_ready[w]. On the next edge:
  - res_z <= X_w << Y_w[4:0]
  - res_id <= w
  - res_valid <= 1
  - ptr <= w
- Shift: logical, zero fill. Y_w[31:5] is ignored, so amounts 0..31 only; Y=32 behaves as shift 0.
- No accept and res_ready & res_valid: res_valid <= 0. res_z and res_id hold their last values.
- No accept and no drain: all state holds, and res_z and res_id stay stable while res_valid==1.
- ptr advances only on accept. A requester that holds valid is served within NREQ accepts (no starvation).
- The block never drops or reorders an accepted request. Requesters are held off rather than overwritten.
- Inputs from a requester need to be stable only in its accept cycle. The arbiter requires no stability beyond that.

## Timing
- Reset values: res_valid=0, res_z=0, res_id=0, ptr=NREQ-1 (so requester 0 has first priority), req_ready=0 while rst_n low.
- Reset asserted mid-operation: a pending result is discarded immediately (res_valid drops asynchronously). The first grant after release goes to the lowest valid index.
- Latency is 1 cycle from accept edge to res_valid=1 with the result.
- Throughput is 1 result per cycle when res_ready stays high.
- res_ready low with res_valid high: all req_ready=0, backpressure within the same cycle.
- res_ready=1 while res_valid=0: ignored.
- A single active requester with valid held is granted every cycle the slot is free. ptr==w does not block re-grant, because the search wraps back to w.

## Test plan
- Reset, then req_valid=0001, X0=0x0000_0001, Y0=4, res_ready=1 -> req_ready=0001 in cycle 0; next cycle res_valid=1, res_z=0x0000_0010, res_id=0.
- All four valid every cycle, res_ready=1, Xi=i+1, Yi=i -> grants in order 0,1,2,3,0; res_z sequence 0x1, 0x4, 0xC, 0x20, 0x1.
- res_valid=1 with res_ready=0 for 3 cycles and requesters 1 and 2 valid -> req_ready=0000 throughout, res_z and res_id stable. When res_ready rises, requester 1 is accepted in that same cycle.
- X=0xFFFF_FFFF: Y=31 -> 0x8000_0000. Y=0x0000_0020 -> 0xFFFF_FFFF (shift 0). Y=0xFFFF_FFE3 -> 0xFFFF_FFF8.
- Pulse rst_n low asynchronously between edges while res_valid=1 -> res_valid=0 immediately. After release with req_valid=1010, requester 1 is granted first.
- NREQ=2 build, only requester 1 valid for 5 cycles with res_ready=1 -> granted every cycle. res_id=1 each cycle, with no idle bubbles.
